// File: rtl/tetris_move_scheduler.sv
// Move/gravity command scheduler for the Tetris field engine: merges key requests and
// the gravity timer into spaced one-hot command pulses, and owns game state and next-piece id.
module tetris_move_scheduler #(
    parameter int unsigned GRAVITY_DIV = 25_000_000,
    parameter int unsigned STEP_DIV    = 2_000_000,
    parameter int unsigned MIN_DIV     = 5_000_000,
    parameter int unsigned ISSUE_GAP   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       keyLeft,
    input  logic       keyRight,
    input  logic       keyDown,
    input  logic       keyRotate,
    input  logic       gameOver,
    input  logic [3:0] level,
    output logic       leftTrue,
    output logic       rightTrue,
    output logic       downTrue,
    output logic       rotateTrue,
    output logic [2:0] blockType,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int GW = $clog2(ISSUE_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP);

    // Command vector bit positions, lowest index = highest issue priority.
    localparam int CD   = 0;
    localparam int CROT = 1;
    localparam int CL   = 2;
    localparam int CR   = 3;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [2:0]    bt_q, bt_d;

    logic [31:0]   lvl_step, period;
    logic [3:0]    keys, grant;
    logic [2:0]    r, cand;
    logic          run, entering, tick, issue_ok;

    always_comb begin
        lvl_step = 32'(level) * STEP_DIV;
        if (lvl_step >= GRAVITY_DIV)
            period = MIN_DIV;
        else if ((GRAVITY_DIV - lvl_step) < MIN_DIV)
            period = MIN_DIV;
        else
            period = GRAVITY_DIV - lvl_step;
    end

    always_comb begin
        state_d  = state_q;
        entering = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: if (start) begin
                state_d  = S_RUN;
                entering = 1'b1;
            end
            S_RUN:   if (gameOver) state_d = S_OVER; else if (pause) state_d = S_PAUSE;
            S_PAUSE: if (gameOver) state_d = S_OVER; else if (pause) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    assign run  = (state_q == S_RUN);
    assign keys = {keyRight, keyLeft, keyRotate, keyDown};
    // >= rather than == so a level raise that shrinks the period below cnt fires at once
    assign tick = run && (cnt_q >= period - 32'd1);
    // Never issue into a clock where the state will no longer be RUN.
    assign issue_ok = run && (state_d == S_RUN) && (gap_q == '0);

    always_comb begin
        grant = '0;
        if (issue_ok) begin
            if (pend_q[CD])        grant[CD]   = 1'b1;
            else if (pend_q[CROT]) grant[CROT] = 1'b1;
            else if (pend_q[CL])   grant[CL]   = 1'b1;
            else if (pend_q[CR])   grant[CR]   = 1'b1;
        end
    end

    assign r    = lfsr_q[2:0];
    assign cand = (r < 3'd6) ? r : r - 3'd2;

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        gap_d  = gap_q;
        cmd_d  = grant;
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        bt_d   = grant[CD] ? cand : bt_q;
        if (entering) begin
            cnt_d  = '0;
            pend_d = '0;
            gap_d  = '0;
        end else begin
            if (run) cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
            // Sets are OR-ed after the clear so a same-clock set survives.
            pend_d = (pend_q & ~grant) | (run ? keys : 4'b0000) | {3'b000, tick};
            if (grant != '0)    gap_d = GAP_LOAD;
            else if (gap_q != '0) gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            gap_q   <= '0;
            cmd_q   <= '0;
            lfsr_q  <= 8'h01;
            bt_q    <= 3'd2;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            cmd_q   <= cmd_d;
            lfsr_q  <= lfsr_d;
            bt_q    <= bt_d;
        end
    end

    assign downTrue   = cmd_q[CD];
    assign rotateTrue = cmd_q[CROT];
    assign leftTrue   = cmd_q[CL];
    assign rightTrue  = cmd_q[CR];
    assign blockType  = bt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed bench for tetris_move_scheduler: cycle table for FSM/issue ordering plus
// hand sequences for gravity periods, long pause, blockType generation and async reset.
module tb_tetris_move_scheduler;

    logic       clock = 1'b0;
    logic       reset, start, pause, keyLeft, keyRight, keyDown, keyRotate, gameOver;
    logic [3:0] level;
    logic       leftTrue, rightTrue, downTrue, rotateTrue;
    logic [2:0] blockType;
    logic [1:0] state;

    int checks = 0;
    int errs   = 0;

    tetris_move_scheduler #(
        .GRAVITY_DIV(10), .STEP_DIV(1), .MIN_DIV(4), .ISSUE_GAP(2)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .keyLeft(keyLeft), .keyRight(keyRight), .keyDown(keyDown), .keyRotate(keyRotate),
        .gameOver(gameOver), .level(level),
        .leftTrue(leftTrue), .rightTrue(rightTrue), .downTrue(downTrue), .rotateTrue(rotateTrue),
        .blockType(blockType), .state(state)
    );

    always #5 clock = ~clock;

    // Reference next-piece LFSR; m_prev is the value the DUT saw at the latest edge.
    logic [7:0] m_lfsr, m_prev;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_lfsr <= 8'h01;
            m_prev <= 8'h01;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    function automatic logic [2:0] cand_of(input logic [7:0] l);
        logic [2:0] v;
        v = l[2:0];
        return (v < 3'd6) ? v : v - 3'd2;
    endfunction

    // {rotate, down, right, left}
    localparam logic [3:0] C_L = 4'b0001, C_R = 4'b0010, C_D = 4'b0100, C_ROT = 4'b1000, C_0 = 4'b0000;
    // {start, pause, kL, kR, kD, kRot, gameOver}
    localparam logic [6:0] I_0 = 7'd0, I_ST = 7'b1000000, I_PA = 7'b0100000, I_KL = 7'b0010000,
                           I_KR = 7'b0001000, I_KD = 7'b0000100, I_KRO = 7'b0000010, I_GO = 7'b0000001;

    typedef struct {
        logic [6:0] in;
        logic [1:0] st;
        logic [3:0] cmd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [6:0] in, input logic [1:0] st, input logic [3:0] cmd);
        vec_t v;
        v.in = in; v.st = st; v.cmd = cmd;
        return v;
    endfunction

    function automatic logic [3:0] cmds();
        return {rotateTrue, downTrue, rightTrue, leftTrue};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        {start, pause, keyLeft, keyRight, keyDown, keyRotate, gameOver} = in;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Edges until downTrue is seen; also counts any non-down command seen on the way.
    task automatic wait_down(input int bound, output int n, output int others);
        n = 0;
        others = 0;
        do begin
            cyc();
            n++;
            if ((cmds() & 4'b1011) != 4'b0000) others++;
        end while (!downTrue && n < bound);
        chk("down_seen", 32'(downTrue), 32'd1);
    endtask

    initial begin
        int n, oth, bad, downs, cycles, bt_bad, rng_bad, hold_bad, dcount;
        logic [2:0] bt_prev;

        reset = 1'b1;
        level = 4'd0;
        drive(I_0);
        repeat (3) cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cmds", 32'(cmds()), 32'd0);
        chk("rst_blocktype", 32'(blockType), 32'd2);
        reset = 1'b0;

        // Period 10 at level 0; comments give gravity cnt after each edge while in RUN.
        vt.push_back(mk(I_0, 2'd0, C_0));
        vt.push_back(mk(I_PA, 2'd0, C_0));                    // pause ignored in IDLE
        vt.push_back(mk(I_KL, 2'd0, C_0));                    // key dropped in IDLE
        vt.push_back(mk(I_ST, 2'd1, C_0));                    // cnt 0
        vt.push_back(mk(I_KL | I_KR | I_KRO, 2'd1, C_0));     // cnt 1
        vt.push_back(mk(I_0, 2'd1, C_ROT));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_L));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_R));                     // cnt 8
        vt.push_back(mk(I_0, 2'd1, C_0));                     // cnt 9
        vt.push_back(mk(I_KD, 2'd1, C_0));                    // gravity tick + keyDown
        vt.push_back(mk(I_0, 2'd1, C_D));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));                     // single down only; cnt 4
        vt.push_back(mk(I_PA, 2'd2, C_0));                    // cnt 5, frozen
        vt.push_back(mk(I_KL, 2'd2, C_0));
        vt.push_back(mk(I_KRO, 2'd2, C_0));
        vt.push_back(mk(I_PA, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));                     // cnt 6
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));                     // cnt 9
        vt.push_back(mk(I_0, 2'd1, C_0));                     // tick
        vt.push_back(mk(I_0, 2'd1, C_D));
        vt.push_back(mk(I_KL, 2'd1, C_0));                    // pL pending
        vt.push_back(mk(I_GO | I_PA, 2'd3, C_0));             // gameOver beats pause, left suppressed
        vt.push_back(mk(I_0, 2'd3, C_0));
        vt.push_back(mk(I_PA, 2'd3, C_0));
        vt.push_back(mk(I_KR, 2'd3, C_0));
        vt.push_back(mk(I_ST, 2'd1, C_0));                    // pend cleared on entry
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_0));
        vt.push_back(mk(I_ST, 2'd1, C_0));                    // start ignored in RUN
        vt.push_back(mk(I_PA, 2'd2, C_0));
        vt.push_back(mk(I_GO, 2'd3, C_0));                    // gameOver from PAUSE
        vt.push_back(mk(I_ST, 2'd1, C_0));
        vt.push_back(mk(I_KD, 2'd1, C_0));
        vt.push_back(mk(I_0, 2'd1, C_D));
        vt.push_back(mk(I_GO, 2'd3, C_0));

        foreach (vt[i]) begin
            drive(vt[i].in);
            cyc();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
            chk($sformatf("vec%0d_cmd", i), 32'(cmds()), 32'(vt[i].cmd));
        end
        drive(I_0);

        // Gravity periods: 10 at level 0, clamps to MIN_DIV=4 at levels 9/10/15, 7 at level 3.
        drive(I_ST); cyc(); drive(I_0);
        chk("grav_start_state", 32'(state), 32'd1);
        wait_down(40, n, oth); chk("grav_first_delay", 32'(n), 32'd11);
        for (int k = 0; k < 3; k++) begin
            wait_down(40, n, oth);
            chk("grav_l0_period", 32'(n), 32'd10);
            chk("grav_l0_no_other", 32'(oth), 32'd0);
        end
        level = 4'd15; wait_down(40, n, oth);
        wait_down(40, n, oth); chk("grav_l15_period", 32'(n), 32'd4);
        wait_down(40, n, oth); chk("grav_l15_period2", 32'(n), 32'd4);
        level = 4'd3; wait_down(40, n, oth);
        wait_down(40, n, oth); chk("grav_l3_period", 32'(n), 32'd7);
        level = 4'd9; wait_down(40, n, oth);
        wait_down(40, n, oth); chk("grav_l9_period", 32'(n), 32'd4);
        level = 4'd10; wait_down(40, n, oth);
        wait_down(40, n, oth); chk("grav_l10_period", 32'(n), 32'd4);

        // Long pause: pause sampled when cnt==7, held 50 clocks with key presses.
        level = 4'd0; wait_down(40, n, oth);
        wait_down(40, n, oth);                                // cnt now 1
        repeat (6) cyc();
        drive(I_PA); cyc(); drive(I_0);
        chk("pause_state", 32'(state), 32'd2);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            drive(i == 10 ? I_KL : i == 20 ? I_KRO : i == 30 ? I_KD : i == 40 ? I_KR : I_0);
            cyc();
            if (cmds() != 4'b0000 || state != 2'd2) bad++;
        end
        drive(I_0);
        chk("pause_quiet", 32'(bad), 32'd0);
        drive(I_PA); cyc(); drive(I_0);
        chk("resume_state", 32'(state), 32'd1);
        wait_down(40, n, oth); chk("resume_down_delay", 32'(n), 32'd3);
        bad = 0; dcount = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if ((cmds() & 4'b1011) != 4'b0000) bad++;
            if (downTrue) dcount++;
        end
        chk("pause_keys_dropped", 32'(bad), 32'd0);
        chk("post_resume_downs", 32'(dcount), 32'd1);

        // blockType over 1000 down commands.
        level = 4'd15;
        downs = 0; cycles = 0; bt_bad = 0; rng_bad = 0; hold_bad = 0;
        bt_prev = blockType;
        while (downs < 1000 && cycles < 6000) begin
            cyc();
            cycles++;
            if (blockType > 3'd5) rng_bad++;
            if (downTrue) begin
                downs++;
                if (blockType !== cand_of(m_prev)) bt_bad++;
            end else if (blockType !== bt_prev) hold_bad++;
            bt_prev = blockType;
        end
        chk("bt_downs", 32'(downs), 32'd1000);
        chk("bt_range", 32'(rng_bad), 32'd0);
        chk("bt_hold", 32'(hold_bad), 32'd0);
        chk("bt_value", 32'(bt_bad), 32'd0);

        // Async reset while a command is on the outputs.
        wait_down(40, n, oth);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_cmds", 32'(cmds()), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        #1 reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (cmds() != 4'b0000 || state != 2'd0) bad++;
        end
        chk("post_rst_idle", 32'(bad), 32'd0);
        chk("post_rst_blocktype", 32'(blockType), 32'd2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
